frame_update_sequencer: RTL and testbench
=========================================

// Module: frame_update_sequencer
// PURPOSE
//  Per-frame game-logic scheduler between beam_establisher and the doodle/platforms datapath.
//  On each frame_start it scans every platform slot, one per cycle, for a doodle landing.
//  It then hands the result to doodle physics with a req/ack handshake.
//  Last, it issues one camera-scroll command, so all state updates land outside visible lines.
// PARAMETERS
//  NUM_PLATFORMS  93   platform slots scanned per frame
//  PLAT_W         64   platform width, px
//  DOODLE_W       40   doodle hitbox width, px
//  HIT_DEPTH      8    vertical landing window below platform top, px
//  SCROLL_LINE    300  screen row; doodle above it triggers scroll
// PORTS
//  clk            in   1   pixel clock
//  rst            in   1   reset, asynchronous, active-low
//  frame_start    in   1   1-cycle pulse at start of vertical blank
//  doodle_x       in   11  doodle left edge, unsigned px
//  doodle_y       in   10  doodle feet row, unsigned px
//  doodle_falling in   1   doodle vertical velocity >= 0
//  plat_idx       out  7   platform slot read address
//  plat_x         in   11  signed platform left edge, valid 1 cycle after plat_idx
//  plat_y         in   11  signed platform top row, same timing
//  plat_active    in   1   slot populated, same timing
//  collision      out  1   landing found this frame
//  collision_y    out  10  plat_y[9:0] of the lowest-index landing platform
//  physics_req    out  1   doodle physics step request
//  physics_ack    in   1   physics step consumed
//  scroll_valid   out  1   1-cycle pulse, scroll_amount valid
//  scroll_amount  out  10  rows to shift world down
//  busy           out  1   high in any state but IDLE
//  overrun        out  1   sticky: frame_start arrived while busy
// BEHAVIOUR
//  Reset:
//   - state=IDLE; plat_idx=0; collision=0; collision_y=0.
//   - physics_req=0; scroll_valid=0; scroll_amount=0; busy=0; overrun=0.
//  FSM states: IDLE -> SCAN -> DRAIN -> PHYS -> SCROLL -> IDLE.
//  IDLE:
//   - On frame_start, latch doodle_x/doodle_y/doodle_falling.
//   - Clear collision, then go to SCAN with plat_idx=0.
//  SCAN:
//   - plat_idx increments each cycle, 0..NUM_PLATFORMS-1.
//   - The slot addressed in cycle k is evaluated in cycle k+1.
//   - After idx NUM_PLATFORMS-1, go to DRAIN (1 cycle, evaluates the last slot).
//  Hit test, 12-bit signed arithmetic:
//   - plat_active & falling_latched
//   - & doodle_y >= plat_y & doodle_y < plat_y+HIT_DEPTH
//   - & doodle_x+DOODLE_W > plat_x & doodle_x < plat_x+PLAT_W.
//   - Negative plat_x/plat_y are legal (partly off-screen).
//  First hit sets collision=1 and collision_y; later hits are ignored (lowest index wins).
//  PHYS:
//   - Entered exactly NUM_PLATFORMS+2 cycles after frame_start.
//   - physics_req=1 until physics_ack is sampled high.
//   - collision and collision_y hold stable while req is high.
//   - ack already high on entry: req lasts 1 cycle.
//   - ack outside PHYS is ignored.
//  SCROLL (1 cycle):
//   - Sample live doodle_y (post-physics).
//   - scroll_amount = SCROLL_LINE-doodle_y if doodle_y < SCROLL_LINE, else 0.
//   - scroll_valid=1 for this cycle, then go to IDLE.
//   - scroll_amount holds until the next SCROLL.
//  collision and collision_y hold until the next frame_start is accepted.
//  frame_start while busy: dropped and overrun set; the sequence in flight is unaffected.
//   - Exception: frame_start in the SCROLL cycle is also dropped with overrun=1.
//  overrun clears only on reset.
//  Reset mid-sequence: immediate return to reset values; no partial scroll or req pulse.
// TESTING
//  - Reset values; frame_start then ack 3 cycles later -> req rises at cycle 95, falls after ack; scroll_valid at ack+1.
//  - Slot 5 {x=100,y=400,active}, doodle (120,403) falling -> collision=1, collision_y=400.
//  - Same, doodle_falling=0 or doodle_y=408 -> collision=0.
//  - Slots 2 (y=400) and 7 (y=402) both hit -> collision_y=400.
//  - Live doodle_y=250 in SCROLL -> scroll_amount=50; doodle_y=300 -> 0.
//  - frame_start at cycle 40 of a scan -> overrun=1, sequence timing unchanged; mid-scan rst -> busy=0.

Source files
------------

// File: rtl/frame_update_sequencer.sv
// Per-frame game-logic scheduler: scans platform slots for a doodle landing,
// hands the result to doodle physics via req/ack, then issues one scroll command.
module frame_update_sequencer #(
  parameter int unsigned NUM_PLATFORMS = 93,
  parameter int unsigned PLAT_W        = 64,
  parameter int unsigned DOODLE_W      = 40,
  parameter int unsigned HIT_DEPTH     = 8,
  parameter int unsigned SCROLL_LINE   = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [10:0] doodle_x,
  input  logic [9:0]  doodle_y,
  input  logic        doodle_falling,
  output logic [6:0]  plat_idx,
  input  logic [10:0] plat_x,
  input  logic [10:0] plat_y,
  input  logic        plat_active,
  output logic        collision,
  output logic [9:0]  collision_y,
  output logic        physics_req,
  input  logic        physics_ack,
  output logic        scroll_valid,
  output logic [9:0]  scroll_amount,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_PHYS   = 3'd3;
  localparam logic [2:0] S_SCROLL = 3'd4;

  localparam logic [6:0]         LAST_IDX   = 7'(NUM_PLATFORMS - 1);
  localparam logic signed [11:0] PLAT_W_S   = 12'(PLAT_W);
  localparam logic signed [11:0] DOODLE_W_S = 12'(DOODLE_W);
  localparam logic signed [11:0] DEPTH_S    = 12'(HIT_DEPTH);
  localparam logic [9:0]         SCROLL_Y   = 10'(SCROLL_LINE);

  logic [2:0]  state, state_d;
  logic [10:0] dx_q;
  logic [9:0]  dy_q;
  logic        falling_q;
  logic        eval_q;      // slot data on plat_* belongs to a scanned index
  logic        hit_c;

  logic signed [11:0] dx_s, dy_s, px_s, py_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (frame_start) state_d = S_SCAN;
      S_SCAN:   if (plat_idx == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_PHYS;
      S_PHYS:   if (physics_ack) state_d = S_SCROLL;
      S_SCROLL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Landing test in 12-bit signed space; platforms may sit partly off-screen
  always_comb begin
    dx_s  = $signed({1'b0, dx_q});
    dy_s  = $signed({2'b00, dy_q});
    px_s  = $signed({plat_x[10], plat_x});
    py_s  = $signed({plat_y[10], plat_y});
    hit_c = eval_q && plat_active && falling_q &&
            (dy_s >= py_s) && (dy_s < py_s + DEPTH_S) &&
            (dx_s + DOODLE_W_S > px_s) && (dx_s < px_s + PLAT_W_S);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_q          <= '0;
      dy_q          <= '0;
      falling_q     <= 1'b0;
      eval_q        <= 1'b0;
      plat_idx      <= '0;
      collision     <= 1'b0;
      collision_y   <= '0;
      physics_req   <= 1'b0;
      scroll_valid  <= 1'b0;
      scroll_amount <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      eval_q       <= (state == S_SCAN);
      physics_req  <= (state_d == S_PHYS);
      scroll_valid <= (state_d == S_SCROLL);
      busy         <= (state_d != S_IDLE);

      if (state == S_IDLE && frame_start) begin
        dx_q        <= doodle_x;
        dy_q        <= doodle_y;
        falling_q   <= doodle_falling;
        collision   <= 1'b0;
        collision_y <= '0;
        plat_idx    <= '0;
      end

      if (state == S_SCAN)
        plat_idx <= (plat_idx == LAST_IDX) ? 7'd0 : plat_idx + 7'd1;

      // Lowest-index landing wins
      if (hit_c && !collision) begin
        collision   <= 1'b1;
        collision_y <= plat_y[9:0];
      end

      // Scroll amount taken from post-physics doodle_y on the ack edge
      if (state == S_PHYS && physics_ack)
        scroll_amount <= (doodle_y < SCROLL_Y) ? SCROLL_Y - doodle_y : 10'd0;

      if (frame_start && state != S_IDLE)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench for frame_update_sequencer: table of landing/scroll frames
// plus hand-written overrun and reset sequences.
module tb_frame_update_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] doodle_x = '0;
  logic [9:0]  doodle_y = '0;
  logic        doodle_falling = 1'b0;
  logic [6:0]  plat_idx;
  logic [10:0] plat_x = '0;
  logic [10:0] plat_y = '0;
  logic        plat_active = 1'b0;
  logic        collision;
  logic [9:0]  collision_y;
  logic        physics_req;
  logic        physics_ack = 1'b0;
  logic        scroll_valid;
  logic [9:0]  scroll_amount;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic [10:0] mem_x [128];
  logic [10:0] mem_y [128];
  logic        mem_a [128];

  frame_update_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .doodle_falling(doodle_falling),
    .plat_idx(plat_idx), .plat_x(plat_x), .plat_y(plat_y), .plat_active(plat_active),
    .collision(collision), .collision_y(collision_y),
    .physics_req(physics_req), .physics_ack(physics_ack),
    .scroll_valid(scroll_valid), .scroll_amount(scroll_amount),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Platform RAM: one-cycle read latency
  always @(posedge clk) begin
    plat_x      <= mem_x[plat_idx];
    plat_y      <= mem_y[plat_idx];
    plat_active <= mem_a[plat_idx];
  end

  typedef struct {
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        fall;
    logic [9:0]  live_y;
    int          ack_dly;
    int          a_idx;
    logic [10:0] a_x;
    logic [10:0] a_y;
    logic        a_on;
    int          b_idx;
    logic [10:0] b_x;
    logic [10:0] b_y;
    logic        b_on;
    logic        exp_col;
    logic [9:0]  exp_y;
    logic [9:0]  exp_scroll;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int id, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (case %0d): got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
      mem_a[i] = 1'b0;
    end
  endtask

  // Start a frame; returns cycle (frame_start cycle = 0) at which physics_req is first seen
  task automatic start_and_wait_req(input int fs_extra_at, output int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 1;
    while (!physics_req && n < 300) begin
      if (n == fs_extra_at) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n++;
    end
  endtask

  task automatic run_vec(input int id);
    vec_t t;
    int   n;
    t = vecs[id];
    clear_mem();
    mem_x[t.a_idx] = t.a_x;
    mem_y[t.a_idx] = t.a_y;
    mem_a[t.a_idx] = t.a_on;
    if (t.b_on) begin
      mem_x[t.b_idx] = t.b_x;
      mem_y[t.b_idx] = t.b_y;
      mem_a[t.b_idx] = 1'b1;
    end
    doodle_x       = t.dx;
    doodle_y       = t.dy;
    doodle_falling = t.fall;
    frame_start    = 1'b1;
    tick();
    frame_start    = 1'b0;
    // Doodle inputs change after acceptance; the latched copy must be used
    doodle_x       = 11'd0;
    doodle_falling = 1'b0;
    doodle_y       = t.live_y;
    if (t.ack_dly == 0) physics_ack = 1'b1;
    check("busy_in_scan", id, int'(busy), 1);
    n = 1;
    while (!physics_req && n < 300) begin
      tick();
      n++;
    end
    check("req_cycle", id, n, 95);
    check("collision", id, int'(collision), int'(t.exp_col));
    if (t.exp_col) check("collision_y", id, int'(collision_y), int'(t.exp_y));
    for (int k = 0; k < t.ack_dly; k++) tick();
    if (t.ack_dly > 0) begin
      check("req_held", id, int'(physics_req), 1);
      check("col_held", id, int'(collision), int'(t.exp_col));
    end
    physics_ack = 1'b1;
    tick();
    physics_ack = 1'b0;
    check("req_drop", id, int'(physics_req), 0);
    check("scroll_valid", id, int'(scroll_valid), 1);
    check("scroll_amount", id, int'(scroll_amount), int'(t.exp_scroll));
    tick();
    check("scroll_pulse_end", id, int'(scroll_valid), 0);
    check("idle_busy", id, int'(busy), 0);
    check("scroll_hold", id, int'(scroll_amount), int'(t.exp_scroll));
  endtask

  initial begin
    int n;
    int seen;

    //            dx      dy      f     live   ack  a_idx a_x       a_y       on    b_idx b_x      b_y      on    col   exp_y        scroll
    vecs[0]  = '{11'd120, 10'd403, 1'b1, 10'd250, 3, 5,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'd400,  10'd50};
    vecs[1]  = '{11'd120, 10'd403, 1'b0, 10'd300, 0, 5,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b0, 10'd0,    10'd0};
    vecs[2]  = '{11'd120, 10'd408, 1'b1, 10'd299, 1, 5,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b0, 10'd0,    10'd1};
    vecs[3]  = '{11'd120, 10'd403, 1'b1, 10'd0,   2, 2,  11'd100,  11'd400,  1'b1, 7, 11'd100, 11'd402, 1'b1, 1'b1, 10'd400,  10'd300};
    vecs[4]  = '{11'd120, 10'd401, 1'b1, 10'd310, 0, 92, 11'd100,  11'd401,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'd401,  10'd0};
    vecs[5]  = '{11'd10,  10'd405, 1'b1, 10'd100, 1, 0,  11'h7EC,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'd400,  10'd200};
    vecs[6]  = '{11'd120, 10'd403, 1'b1, 10'd250, 1, 3,  11'd160,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b0, 10'd0,    10'd50};
    vecs[7]  = '{11'd163, 10'd403, 1'b1, 10'd250, 1, 3,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'd400,  10'd50};
    vecs[8]  = '{11'd164, 10'd403, 1'b1, 10'd250, 2, 3,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b0, 10'd0,    10'd50};
    vecs[9]  = '{11'd120, 10'd403, 1'b1, 10'd250, 1, 4,  11'd100,  11'd400,  1'b0, 0, 11'd0,   11'd0,   1'b0, 1'b0, 10'd0,    10'd50};
    vecs[10] = '{11'd120, 10'd0,   1'b1, 10'd250, 1, 10, 11'd100,  11'h7FB,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'h3FB,  10'd50};
    vecs[11] = '{11'd120, 10'd400, 1'b1, 10'd299, 2, 6,  11'd100,  11'd400,  1'b1, 0, 11'd0,   11'd0,   1'b0, 1'b1, 10'd400,  10'd1};

    clear_mem();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_plat_idx", 0, int'(plat_idx), 0);
    check("rst_collision", 0, int'(collision), 0);
    check("rst_collision_y", 0, int'(collision_y), 0);
    check("rst_req", 0, int'(physics_req), 0);
    check("rst_scroll_valid", 0, int'(scroll_valid), 0);
    check("rst_scroll_amount", 0, int'(scroll_amount), 0);
    check("rst_busy", 0, int'(busy), 0);
    check("rst_overrun", 0, int'(overrun), 0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 12; i++) run_vec(i);
    check("no_overrun_yet", 0, int'(overrun), 0);

    // frame_start during the scan is dropped, timing unchanged
    clear_mem();
    doodle_y = 10'd250;
    start_and_wait_req(40, n);
    check("ovr_req_cycle", 100, n, 95);
    check("ovr_flag", 100, int'(overrun), 1);
    physics_ack = 1'b1;
    tick();
    physics_ack = 1'b0;
    check("ovr_scroll_valid", 100, int'(scroll_valid), 1);
    tick();

    // frame_start in the SCROLL cycle is dropped as well
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_and_wait_req(-1, n);
    check("scr_req_cycle", 101, n, 95);
    physics_ack = 1'b1;
    tick();
    physics_ack = 1'b0;
    check("scr_scroll_valid", 101, int'(scroll_valid), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("scr_overrun", 101, int'(overrun), 1);
    check("scr_not_started", 101, int'(busy), 0);
    tick();
    check("scr_still_idle", 101, int'(busy), 0);

    // Reset mid-scan: immediate return, no later req or scroll pulse
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    check("mid_busy_before", 102, int'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_busy", 102, int'(busy), 0);
    check("mid_plat_idx", 102, int'(plat_idx), 0);
    check("mid_overrun", 102, int'(overrun), 0);
    check("mid_req", 102, int'(physics_req), 0);
    tick();
    rst = 1'b1;
    physics_ack = 1'b1;
    seen = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (physics_req || scroll_valid || busy) seen++;
    end
    physics_ack = 1'b0;
    check("mid_no_activity", 102, seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
